// File: rtl/id_hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline (ID branch compare + EX ALU operands).
// Optional stall-cycle counter port perf_stall_cnt is built only when HAZARD_PERF_EN is defined.
module id_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic [FWD_W-1:0]      rs1_fwd_id,
    output logic [FWD_W-1:0]      rs2_fwd_id,
    output logic [FWD_W-1:0]      rs1_fwd_ex,
    output logic [FWD_W-1:0]      rs2_fwd_ex,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt
`endif
);

    typedef enum logic [FWD_W-1:0] {
        FROM_REG = 2'b00,
        FROM_MEM = 2'b01,
        FROM_WB  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  load;
    } stage_t;

    // WB is not shadowed: the register file is write-before-read, so no decision depends on it.
    stage_t ex_q;
    stage_t mem_q;
    fwd_e   rs1_fwd_ex_q;
    fwd_e   rs2_fwd_ex_q;
    logic   stall;
    logic   advance;
    fwd_e   rs1_fwd_ex_d;
    fwd_e   rs2_fwd_ex_d;

    function automatic logic writes(input stage_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.wr & (s.rd == r) & (r != '0);
    endfunction

    function automatic logic src_stall(input stage_t ex, input stage_t mem, input logic branch,
                                       input logic [REG_ADDR_W-1:0] r);
        if (branch)
            return writes(ex, r) | (writes(mem, r) & mem.load);
        return writes(ex, r) & ex.load;
    endfunction

    function automatic fwd_e id_sel(input stage_t mem, input logic [REG_ADDR_W-1:0] r);
        return (writes(mem, r) & ~mem.load) ? FROM_MEM : FROM_REG;
    endfunction

    function automatic fwd_e ex_sel(input stage_t ex, input stage_t mem, input logic [REG_ADDR_W-1:0] r);
        if (writes(ex, r))
            return FROM_MEM;
        if (writes(mem, r))
            return FROM_WB;
        return FROM_REG;
    endfunction

    always_comb begin
        stall        = (id_use_rs1 & src_stall(ex_q, mem_q, id_is_branch, id_rs1)) |
                       (id_use_rs2 & src_stall(ex_q, mem_q, id_is_branch, id_rs2));
        advance      = id_valid & ~stall;
        rs1_fwd_ex_d = FROM_REG;
        rs2_fwd_ex_d = FROM_REG;
        if (advance) begin
            rs1_fwd_ex_d = ex_sel(ex_q, mem_q, id_rs1);
            rs2_fwd_ex_d = ex_sel(ex_q, mem_q, id_rs2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            rs1_fwd_ex_q <= FROM_REG;
            rs2_fwd_ex_q <= FROM_REG;
        end else begin
            mem_q        <= ex_q;
            rs1_fwd_ex_q <= rs1_fwd_ex_d;
            rs2_fwd_ex_q <= rs2_fwd_ex_d;
            if (advance) begin
                ex_q.valid <= 1'b1;
                ex_q.rd    <= id_rd;
                ex_q.wr    <= id_reg_write;
                ex_q.load  <= id_mem_read;
            end else begin
                ex_q.valid <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_stall_cnt <= '0;
        else if (stall && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

    assign rs1_fwd_id = id_sel(mem_q, id_rs1);
    assign rs2_fwd_id = id_sel(mem_q, id_rs2);
    assign rs1_fwd_ex = rs1_fwd_ex_q;
    assign rs2_fwd_ex = rs2_fwd_ex_q;
    assign stall_id   = stall;
    assign stall_if   = stall;
    assign bubble_ex  = stall & id_valid;
    assign flush_if   = branch_taken & id_valid & ~stall;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Self-checking bench for id_hazard_unit: directed vector table, then random stimulus against a pipeline model.
// Counter checks are compiled in only when HAZARD_PERF_EN is defined.
module tb_id_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_is_branch;
    logic        id_reg_write, id_mem_read, branch_taken;
    logic [1:0]  rs1_fwd_id, rs2_fwd_id, rs1_fwd_ex, rs2_fwd_ex;
    logic        stall_if, stall_id, bubble_ex, flush_if;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    id_hazard_unit #(.REG_ADDR_W(5), .FWD_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .rs1_fwd_id(rs1_fwd_id), .rs2_fwd_id(rs2_fwd_id),
        .rs1_fwd_ex(rs1_fwd_ex), .rs2_fwd_ex(rs2_fwd_ex),
        .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_if(flush_if)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit valid; int rs1; int rs2; bit u1; bit u2; bit br;
        int rd; bit wr; bit ld; bit tk;
        bit st; bit fl; int fid1; int fid2; int fex1; int fex2; int perf;
    } vec_t;

    typedef struct { bit valid; int rd; bit wr; bit load; } mstage_t;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    mstage_t         pipe[3];
    int              m_fex[2];
    longint unsigned m_perf;
    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;
    vec_t            tbl[$];

    function automatic vec_t mk(bit rst, bit v, int rs1, int rs2, bit u1, bit u2, bit br, int rd,
                                bit wr, bit ld, bit tk, bit st, bit fl,
                                int fid1, int fid2, int fex1, int fex2, int perf);
        vec_t r;
        r.rst = rst; r.valid = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.br = br;
        r.rd = rd; r.wr = wr; r.ld = ld; r.tk = tk; r.st = st; r.fl = fl;
        r.fid1 = fid1; r.fid2 = fid2; r.fex1 = fex1; r.fex2 = fex2; r.perf = perf;
        return r;
    endfunction

    function automatic vec_t nop(bit rst, int perf);
        return mk(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, perf);
    endfunction

    function automatic bit m_writes(int s, int r);
        return pipe[s].valid && pipe[s].wr && (pipe[s].rd == r) && (r != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{valid: 0, rd: 0, wr: 0, load: 0};
        m_fex[0] = 0; m_fex[1] = 0; m_perf = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit tab);
        int src[2]; bit use_s[2]; int fid[2]; int fnx[2];
        bit st, fl, adv;
        rst_n = v.rst; id_valid = v.valid; id_rs1 = 5'(v.rs1); id_rs2 = 5'(v.rs2);
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_is_branch = v.br; id_rd = 5'(v.rd);
        id_reg_write = v.wr; id_mem_read = v.ld; branch_taken = v.tk;
        src[0] = v.rs1; src[1] = v.rs2; use_s[0] = v.u1; use_s[1] = v.u2;
        st = 0;
        for (int i = 0; i < 2; i++) begin
            if (use_s[i]) begin
                if (v.br) begin
                    if (m_writes(0, src[i]) || (m_writes(1, src[i]) && pipe[1].load)) st = 1;
                end else if (m_writes(0, src[i]) && pipe[0].load) begin
                    st = 1;
                end
            end
            fid[i] = (m_writes(1, src[i]) && !pipe[1].load) ? 1 : 0;
        end
        adv = v.valid && !st;
        for (int i = 0; i < 2; i++)
            fnx[i] = !adv ? 0 : m_writes(0, src[i]) ? 1 : m_writes(1, src[i]) ? 2 : 0;
        fl = v.tk && v.valid && !st;
        if (tab) begin
            st = v.st; fl = v.fl; fid[0] = v.fid1; fid[1] = v.fid2;
        end
        #4;
        chk("stall_id", 32'(stall_id), 32'(st));
        chk("stall_if", 32'(stall_if), 32'(st));
        chk("bubble_ex", 32'(bubble_ex), 32'(st & v.valid));
        chk("flush_if", 32'(flush_if), 32'(fl));
        chk("rs1_fwd_id", 32'(rs1_fwd_id), 32'(fid[0]));
        chk("rs2_fwd_id", 32'(rs2_fwd_id), 32'(fid[1]));
        @(posedge clk);
        if (!v.rst) begin
            model_reset();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (adv) pipe[0] = '{valid: 1, rd: v.rd, wr: v.wr, load: v.ld};
            else     pipe[0].valid = 0;
            m_fex = fnx;
            if (st && m_perf != 64'hFFFF_FFFF) m_perf++;
        end
        #1;
        cyc++;
        chk("rs1_fwd_ex", 32'(rs1_fwd_ex), 32'(tab ? v.fex1 : m_fex[0]));
        chk("rs2_fwd_ex", 32'(rs2_fwd_ex), 32'(tab ? v.fex2 : m_fex[1]));
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, (tab && v.perf >= 0) ? 32'(v.perf) : 32'(m_perf));
`endif
    endtask

    initial begin
        // addi x5 ; add x6,x5,x5
        tbl.push_back(nop(0, -1));
        tbl.push_back(mk(1,1,1,0,1,0,0,5,1,0,0, 0,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,5,5,1,1,0,6,1,0,0, 0,0,0,0,1,1,-1));
        repeat (3) tbl.push_back(nop(1, -1));
        // lw x5 ; add x7,x5,x1
        tbl.push_back(mk(1,1,2,0,1,0,0,5,1,1,0, 0,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,5,1,1,1,0,7,1,0,0, 1,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,5,1,1,1,0,7,1,0,0, 0,0,0,0,2,0,-1));
        repeat (3) tbl.push_back(nop(1, -1));
        // lw x5 ; beq x5,x0 taken throughout the stall
        tbl.push_back(mk(1,1,2,0,1,0,0,5,1,1,0, 0,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 1,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 1,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 0,1,0,0,0,0,-1));
        repeat (3) tbl.push_back(nop(1, -1));
        // addi x8 ; nop ; bne x8,x9
        tbl.push_back(mk(1,1,1,0,1,0,0,8,1,0,0, 0,0,0,0,0,0,-1));
        tbl.push_back(nop(1, -1));
        tbl.push_back(mk(1,1,8,9,1,1,1,0,0,0,0, 0,0,1,0,2,0,-1));
        repeat (3) tbl.push_back(nop(1, -1));
        // addi x0 ; nop ; bne x0,x9
        tbl.push_back(mk(1,1,1,0,1,0,0,0,1,0,0, 0,0,0,0,0,0,-1));
        tbl.push_back(nop(1, -1));
        tbl.push_back(mk(1,1,0,9,1,1,1,0,0,0,0, 0,0,0,0,0,0,-1));
        tbl.push_back(nop(1, -1));
        // taken branch, no hazard
        tbl.push_back(mk(1,1,1,2,1,1,1,0,0,0,1, 0,1,0,0,0,0,-1));
        tbl.push_back(nop(1, -1));
        // addi x3 ; beq x3,x4 -> one ALU stall, then MEM forward
        tbl.push_back(mk(1,1,1,0,1,0,0,3,1,0,0, 0,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,3,4,1,1,1,0,0,0,0, 1,0,0,0,0,0,-1));
        tbl.push_back(mk(1,1,3,4,1,1,1,0,0,0,0, 0,0,1,0,2,0,-1));
        tbl.push_back(nop(1, -1));
        // from reset: lw/beq stall count, then reset in the middle of a second stall
        tbl.push_back(nop(0, 0));
        tbl.push_back(mk(1,1,2,0,1,0,0,5,1,1,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 1,0,0,0,0,0,1));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 1,0,0,0,0,0,2));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 0,1,0,0,0,0,2));
        tbl.push_back(mk(1,1,2,0,1,0,0,5,1,1,0, 0,0,0,0,0,0,2));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 1,0,0,0,0,0,3));
        tbl.push_back(mk(0,1,5,0,1,1,1,0,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,5,0,1,1,1,0,0,0,1, 0,1,0,0,0,0,0));
        tbl.push_back(nop(1, 0));

        rst_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_is_branch = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0; branch_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], 1'b1);

        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v = mk(($urandom % 50) != 0, ($urandom % 4) != 0, $urandom % 8, $urandom % 8,
                   $urandom % 2, $urandom % 2, ($urandom % 3) == 0, $urandom % 8,
                   $urandom % 2, 0, $urandom % 2, 0, 0, 0, 0, 0, 0, -1);
            v.ld = v.wr && ($urandom % 2);
            step(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
